// File: rtl/cpu_ifetch_pkg.sv
// cpu_ifetch_pkg: shared widths and fetch FSM state encodings for the instruction-fetch front end
package cpu_ifetch_pkg;
  localparam int WIDTH = 16;
  localparam int IADDR_WIDTH = 10;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2,
    DRAIN    = 2'd3
  } ifetch_state_e;
endpackage

// File: rtl/cpu_ifetch_slot.sv
// cpu_ifetch_slot: one address/data/valid instruction register with load, clear and hit compare
// ports: clk, reset (sync, active-low), load/load_addr/load_data, clear (wins over load),
//        cmp_addr in; addr/data/valid contents and hit (valid & addr==cmp_addr) out
module cpu_ifetch_slot
  import cpu_ifetch_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int iaddr_width = IADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   clear,
  input  logic [iaddr_width-1:0] load_addr,
  input  logic [width-1:0]       load_data,
  input  logic [iaddr_width-1:0] cmp_addr,
  output logic [iaddr_width-1:0] addr,
  output logic [width-1:0]       data,
  output logic                   valid,
  output logic                   hit
);
  assign hit = valid && addr == cmp_addr;
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr  <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      addr  <= load_addr;
      data  <= load_data;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/cpu_ifetch.sv
// cpu_ifetch: instruction fetch front end with current/next-word registers and one-deep memory handshake
// ports: clk, reset (sync, active-low); core side iaddr in, idata/stall out, inv in;
//        memory side mem_req/mem_addr out, mem_ack/mem_rdata in
module cpu_ifetch
  import cpu_ifetch_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int iaddr_width = IADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [iaddr_width-1:0] iaddr,
  output logic [width-1:0]       idata,
  output logic                   stall,
  input  logic                   inv,
  output logic                   mem_req,
  output logic [iaddr_width-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [width-1:0]       mem_rdata
);
  ifetch_state_e state, state_nxt;
  logic [iaddr_width-1:0] cur_a, nxt_a, pf_base, addr_nxt;
  logic [width-1:0] cur_d, nxt_d, hold;
  logic cur_v, nxt_v, hit_cur, hit_nxt, miss, ack, promote, cur_fill, nxt_fill, req_nxt;
  assign miss = !hit_cur && !hit_nxt;
  assign ack = mem_ack && mem_req;
  // a demand completing this cycle owns the CUR load, so promotion waits
  assign promote = hit_nxt && !hit_cur && !inv && !(ack && state == DEMAND);
  assign pf_base = promote ? nxt_a : cur_a;
  assign idata = hit_cur ? cur_d : hit_nxt ? nxt_d : hold;
  assign stall = miss;
  cpu_ifetch_slot #(.width(width), .iaddr_width(iaddr_width)) u_cur (
    .clk(clk), .reset(reset), .load(cur_fill || promote), .clear(inv),
    .load_addr(cur_fill ? mem_addr : nxt_a), .load_data(cur_fill ? mem_rdata : nxt_d),
    .cmp_addr(iaddr), .addr(cur_a), .data(cur_d), .valid(cur_v), .hit(hit_cur)
  );
  cpu_ifetch_slot #(.width(width), .iaddr_width(iaddr_width)) u_nxt (
    .clk(clk), .reset(reset), .load(nxt_fill), .clear(inv || (promote && !nxt_fill)),
    .load_addr(mem_addr), .load_data(mem_rdata),
    .cmp_addr(iaddr), .addr(nxt_a), .data(nxt_d), .valid(nxt_v), .hit(hit_nxt)
  );
  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    addr_nxt  = mem_addr;
    cur_fill  = 1'b0;
    nxt_fill  = 1'b0;
    if (inv) begin
      state_nxt = ack ? IDLE : mem_req ? DRAIN : state;
      req_nxt   = mem_req && !ack;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state_nxt = DEMAND;
            req_nxt   = 1'b1;
            addr_nxt  = iaddr;
          end else if (promote || (cur_v && (!nxt_v || nxt_a != cur_a + iaddr_width'(1)))) begin
            state_nxt = PREFETCH;
            req_nxt   = 1'b1;
            addr_nxt  = pf_base + iaddr_width'(1);
          end
        end
        DEMAND: begin
          cur_fill  = ack;
          state_nxt = ack ? IDLE : DEMAND;
          req_nxt   = !ack;
        end
        PREFETCH: begin
          // the core jumping onto the word being prefetched takes it straight into CUR
          cur_fill  = ack && miss && iaddr == mem_addr;
          nxt_fill  = ack && !(miss && iaddr == mem_addr);
          state_nxt = ack ? IDLE : miss ? DRAIN : PREFETCH;
          req_nxt   = !ack;
        end
        DRAIN: begin
          state_nxt = ack ? (miss ? DEMAND : IDLE) : DRAIN;
          req_nxt   = !ack || miss;
          addr_nxt  = ack && miss ? iaddr : mem_addr;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      hold     <= '0;
    end else begin
      state    <= state_nxt;
      mem_req  <= req_nxt;
      mem_addr <= addr_nxt;
      hold     <= miss ? hold : idata;
    end
  end
endmodule
